muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: restoring radix-2 divider and shift-add multiplier.
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally (single-cycle).
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [2:0]      MD_OP,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);
    localparam int unsigned      CNT_W     = $clog2(XLEN);
    localparam int unsigned      PW        = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  W_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  W_ONES    = '1;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           r_state, w_state_nx;
    logic [2:0]       r_op;
    logic [XLEN-1:0]  r_b, r_hi, r_lo, r_result;
    logic             r_neg_res, r_neg_rem, r_busy, r_done;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1, w_s2, w_neg1, w_neg2, w_div_zero, w_div_ovf, w_early;
    logic [XLEN-1:0]  w_mag1, w_mag2, w_early_res;
    logic [XLEN:0]    w_rem_sh, w_diff, w_sum;
    logic [XLEN-1:0]  w_hi_step, w_lo_step, w_q, w_r, w_fin_res, w_res_nx;
    logic [PW-1:0]    w_prod, w_prod_s;
    logic             w_load_op, w_step, w_load_res;

    // Operand signedness per op: MUL/MULH/DIV/REM s*s, MULHSU s*u, rest u*u
    always_comb begin
        w_s1 = 1'b0;
        w_s2 = 1'b0;
        case (MD_OP)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_s1 = 1'b1;
                w_s2 = 1'b1;
            end
            3'b010:  w_s1 = 1'b1;
            default: w_s1 = 1'b0;
        endcase
    end

    assign w_neg1     = w_s1 & OPERAND1[XLEN-1];
    assign w_neg2     = w_s2 & OPERAND2[XLEN-1];
    assign w_mag1     = w_neg1 ? (~OPERAND1 + XLEN'(1)) : OPERAND1;
    assign w_mag2     = w_neg2 ? (~OPERAND2 + XLEN'(1)) : OPERAND2;
    assign w_div_zero = MD_OP[2] & (OPERAND2 == '0);
    assign w_div_ovf  = MD_OP[2] & ~MD_OP[0] & (OPERAND1 == W_MIN_NEG) & (OPERAND2 == W_ONES);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [PW-1:0] w_fx1, w_fx2, w_fprod;
    assign w_fx1   = PW'($signed({w_s1 & OPERAND1[XLEN-1], OPERAND1}));
    assign w_fx2   = PW'($signed({w_s2 & OPERAND2[XLEN-1], OPERAND2}));
    assign w_fprod = w_fx1 * w_fx2;
    assign w_early = w_div_zero | w_div_ovf | ~MD_OP[2];
`else
    assign w_early = w_div_zero | w_div_ovf;
`endif

    // Results that bypass CALC entirely
    always_comb begin
        w_early_res = MD_OP[1] ? '0 : W_MIN_NEG;
        if (w_div_zero)
            w_early_res = MD_OP[1] ? OPERAND1 : W_ONES;
`ifdef MULDIV_FAST_MUL_EN
        if (!MD_OP[2])
            w_early_res = (MD_OP[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[PW-1:XLEN];
`endif
    end

    // One iteration of divide (hi=remainder, lo=quotient) or multiply (hi:lo=product)
    always_comb begin
        w_rem_sh = {r_hi, r_lo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_b};
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        if (r_op[2]) begin
            w_hi_step = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            w_lo_step = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
            w_hi_step = w_sum[XLEN:1];
            w_lo_step = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod   = {w_hi_step, w_lo_step};
        w_prod_s = r_neg_res ? (~w_prod + PW'(1)) : w_prod;
        w_q      = r_neg_res ? (~w_lo_step + XLEN'(1)) : w_lo_step;
        w_r      = r_neg_rem ? (~w_hi_step + XLEN'(1)) : w_hi_step;
        if (r_op[2])
            w_fin_res = r_op[1] ? w_r : w_q;
        else
            w_fin_res = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[PW-1:XLEN];
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nx = r_state;
        w_load_op  = 1'b0;
        w_step     = 1'b0;
        w_load_res = 1'b0;
        w_res_nx   = w_fin_res;
        case (r_state)
            IDLE: begin
                if (START && !FLUSH) begin
                    w_load_op = 1'b1;
                    if (w_early) begin
                        w_state_nx = FINISH;
                        w_load_res = 1'b1;
                        w_res_nx   = w_early_res;
                    end else begin
                        w_state_nx = CALC;
                    end
                end
            end
            CALC: begin
                if (FLUSH) begin
                    w_state_nx = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nx = FINISH;
                        w_load_res = 1'b1;
                    end
                end
            end
            FINISH:  w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != IDLE);
            r_done  <= (w_state_nx == FINISH);
            if (w_load_op) begin
                r_op      <= MD_OP;
                r_b       <= w_mag2;
                r_hi      <= '0;
                r_lo      <= w_mag1;
                r_neg_res <= w_neg1 ^ w_neg2;
                r_neg_rem <= w_neg1;
                r_cnt     <= '0;
            end else if (w_step) begin
                r_hi  <= w_hi_step;
                r_lo  <= w_lo_step;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load_res)
                r_result <= w_res_nx;
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RESULT = r_result;

endmodule
